// File: rtl/and_gate.sv
// ============================================================================
// and_gate : registered bitwise AND with all/any/rise flags and a saturating
//            rise counter. Optional input synchronizers: AND_GATE_SYNC_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module and_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             S_all,
  output logic             S_any,
  output logic             S_rise,
  output logic [CNT_W-1:0] CNT
);

  logic [WIDTH-1:0] a_src;
  logic [WIDTH-1:0] b_src;

`ifdef AND_GATE_SYNC_EN
  // Two-flop synchronizers; operands may be asynchronous to clk.
  logic [WIDTH-1:0] a_s1_q, a_s2_q, b_s1_q, b_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_s1_q <= '0;
      a_s2_q <= '0;
      b_s1_q <= '0;
      b_s2_q <= '0;
    end else begin
      a_s1_q <= A;
      a_s2_q <= a_s1_q;
      b_s1_q <= B;
      b_s2_q <= b_s1_q;
    end
  end

  assign a_src = a_s2_q;
  assign b_src = b_s2_q;
`else
  assign a_src = A;
  assign b_src = B;
`endif

  logic [WIDTH-1:0] s_d, s_q;
  logic             all_d, all_q;
  logic             any_d, any_q;
  logic             rise_d, rise_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    s_d    = a_src & b_src;
    all_d  = &s_d;
    any_d  = |s_d;
    rise_d = all_d & ~all_q;
    cnt_d  = cnt_q;
    // Count the pulse already on S_rise, holding at the all-ones ceiling.
    if (rise_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      all_q  <= 1'b0;
      any_q  <= 1'b0;
      rise_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s_q    <= s_d;
      all_q  <= all_d;
      any_q  <= any_d;
      rise_q <= rise_d;
      cnt_q  <= cnt_d;
    end
  end

  assign S      = s_q;
  assign S_all  = all_q;
  assign S_any  = any_q;
  assign S_rise = rise_q;
  assign CNT    = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_and_gate.sv
// Bench for and_gate: a 4-bit/2-bit-counter instance and a 1-bit/8-bit-counter
// instance driven together, checked against a behavioural model.
`default_nettype none

module tb_and_gate;

`ifdef AND_GATE_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] A, B;

  logic [3:0] s0;
  logic       all0, any0, rise0;
  logic [1:0] cnt0;
  logic [0:0] s1;
  logic       all1, any1, rise1;
  logic [7:0] cnt1;

  int checks   = 0;
  int failures = 0;

  and_gate #(.WIDTH(4), .CNT_W(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B),
    .S(s0), .S_all(all0), .S_any(any0), .S_rise(rise0), .CNT(cnt0)
  );

  and_gate #(.WIDTH(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .A(A[0:0]), .B(B[0:0]),
    .S(s1), .S_all(all1), .S_any(any1), .S_rise(rise1), .CNT(cnt1)
  );

  always #5 clk = ~clk;

  // Model state: index 0 -> 4-bit instance, index 1 -> 1-bit instance.
  logic [3:0] hist[$];
  logic [3:0] e_s    [2];
  logic       e_all  [2];
  logic       e_any  [2];
  logic       e_rise [2];
  int         e_cnt  [2];
  logic [3:0] mask   [2] = '{4'hF, 4'h1};
  int         cmax   [2] = '{3, 255};

  task automatic model_reset();
    hist.delete();
    for (int m = 0; m < 2; m++) begin
      e_s[m] = '0; e_all[m] = 1'b0; e_any[m] = 1'b0; e_rise[m] = 1'b0; e_cnt[m] = 0;
    end
  endtask

  // The AND seen at an edge is the one applied LAT-1 edges earlier (zero if
  // that lies before reset release).
  task automatic model_edge(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    hist.push_back(a & b);
    r = (hist.size() >= LAT) ? hist[hist.size() - LAT] : 4'h0;
    for (int m = 0; m < 2; m++) begin
      logic [3:0] rm;
      logic       full;
      rm   = r & mask[m];
      full = (rm == mask[m]);
      if (e_rise[m] && e_cnt[m] < cmax[m]) e_cnt[m] = e_cnt[m] + 1;
      e_rise[m] = full && !e_all[m];
      e_s[m]    = rm;
      e_all[m]  = full;
      e_any[m]  = (rm != 4'h0);
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".S0"},    int'(s0),    int'(e_s[0]));
    check({tag, ".all0"},  int'(all0),  int'(e_all[0]));
    check({tag, ".any0"},  int'(any0),  int'(e_any[0]));
    check({tag, ".rise0"}, int'(rise0), int'(e_rise[0]));
    check({tag, ".cnt0"},  int'(cnt0),  e_cnt[0]);
    check({tag, ".S1"},    int'(s1),    int'(e_s[1]));
    check({tag, ".all1"},  int'(all1),  int'(e_all[1]));
    check({tag, ".any1"},  int'(any1),  int'(e_any[1]));
    check({tag, ".rise1"}, int'(rise1), int'(e_rise[1]));
    check({tag, ".cnt1"},  int'(cnt1),  e_cnt[1]);
    // With one bit, S, S_all and S_any must coincide.
    check({tag, ".w1eq"},  int'({s1, all1}), int'({any1, any1}));
  endtask

  task automatic step(input string tag, input logic [3:0] a, input logic [3:0] b);
    A = a;
    B = b;
    @(posedge clk);
    model_edge(a, b);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [3:0] ra, rb;
    // Reset held with all-ones operands and a running clock.
    rst_n = 1'b0;
    A = 4'hF;
    B = 4'hF;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");

    rst_n = 1'b1;
    // Truth table, each pattern held for two edges.
    step("tt00", 4'h0, 4'h0); step("tt00", 4'h0, 4'h0);
    step("tt01", 4'h0, 4'h1); step("tt01", 4'h0, 4'h1);
    step("tt10", 4'h1, 4'h0); step("tt10", 4'h1, 4'h0);
    step("tt11", 4'h1, 4'h1); step("tt11", 4'h1, 4'h1);
    repeat (LAT) step("tt11h", 4'h1, 4'h1);

    // Vector patterns.
    repeat (LAT) step("vec_c_a", 4'b1100, 4'b1010);
    check("vec.S", int'(s0), 8);
    repeat (LAT) step("vec_ff", 4'hF, 4'hF);
    step("vec_ff2", 4'hF, 4'hF);

    // Saturation of the 2-bit counter.
    for (int i = 0; i < 6; i++) begin
      repeat (LAT) step("sat_lo", 4'h0, 4'hF);
      repeat (LAT) step("sat_hi", 4'hF, 4'hF);
    end
    step("sat_end", 4'h0, 4'hF);
    check("sat.cnt0", int'(cnt0), 3);

    // Randomized operands, biased toward all-ones.
    for (int i = 0; i < 200; i++) begin
      ra = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      rb = ($urandom_range(0, 2) != 0) ? 4'hF : 4'($urandom);
      step("rand", ra, rb);
    end

    // Asynchronous reset between edges while S is non-zero.
    repeat (LAT + 1) step("pre_rst", 4'hF, 4'hF);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #2;
    A = 4'hF;
    B = 4'hF;
    rst_n = 1'b1;
    repeat (LAT) step("post_rst", 4'hF, 4'hF);
    check("post_rst.rise0", int'(rise0), 1);
    step("post_rst2", 4'hF, 4'hF);
    check("post_rst.cnt1", int'(cnt1), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
